onehot_event_encoder: RTL
=========================

Name: onehot_event_encoder

Overview:
- Reverse direction of the team's 3-to-8 decoder. Accepts up to 8 independent single-bit event lines and queues them in a pending register.
- Emits each pending event, one at a time, as a 3-bit index through a valid/ready output stage. Highest index first.
- Sits between interrupt/event sources and any consumer that expects an encoded index. Its one-hot echo output feeds straight back into a decoder for self-check.

Parameters:
- N, 8, number of event lines; fixed at 8 for this revision.
- IW, 3, index width; must equal clog2(N).

Ports:
- clk  input  1  rising-edge clock, only clock.
- rst  input  1  synchronous, active-high reset.
- enb  input  1  capture enable; when low, inpt is ignored.
- inpt  input  8  event request lines; bit i high in a cycle = one event on line i.
- out_rdy  input  1  consumer ready.
- out_vld  output  1  out_idx holds a valid event.
- out_idx  output  3  encoded index of the presented event.
- out_onehot  output  8  one-hot of out_idx when out_vld, else 0.
- pend  output  8  current pending register.
- pend_cnt  output  4  popcount of pend, range 0..8.
- ovf  output  1  sticky: an event was merged into an already-pending bit.

Behaviour:
- Reset (rst high at a clk edge), all registered state cleared:
  - pend=0, out_vld=0, out_idx=0, ovf=0.
  - out_onehot and pend_cnt follow as 0.
  - Reset mid-transfer discards the presented event and all pending events; nothing is emitted afterwards.
- rst has priority over every other input.
- Definitions:
  - free = !out_vld || out_rdy.
  - sel = index of highest set bit of pend.
  - load = free && (pend != 0).
- Output register, per clk edge:
  - If load: out_idx <= sel, out_vld <= 1.
  - Else if free: out_vld <= 0, out_idx holds its last value.
  - Else (out_vld && !out_rdy): out_vld and out_idx held stable. No change while stalled.
- Handshake:
  - An event is consumed at the edge where out_vld && out_rdy.
  - Back-to-back: with out_rdy held high and pend non-empty, a new index is presented every cycle.
- Pending register, per clk edge:
  - pend <= (pend & ~(load ? onehot(sel) : 0)) | (enb ? inpt : 0).
  - A bit leaves pend at the edge it is loaded into the output register, not at the handshake.
- Simultaneous events:
  - If inpt[sel] is high and enb is high in the cycle where sel is loaded, bit sel is re-set. It counts as a new event, not overflow.
  - Multiple inpt bits in one cycle are all captured.
- Overflow:
  - ovf <= ovf | (enb && inpt[i] && pend[i] && !(load && sel==i)), for any i.
  - ovf is cleared only by rst. The merged event is lost; pend is unaffected.
- Latency:
  - inpt[i] sampled at edge k → pend[i]=1 after edge k.
  - If the output is free and i is the highest pending bit, out_vld=1 with out_idx=i after edge k+1. Minimum input-to-valid latency is 2 cycles.
- Priority:
  - Strict highest-index-first.
  - Lower lines can starve under sustained higher-line traffic. This is required, not a bug.
- enb low: inpt ignored entirely (no capture, no ovf update). pend continues to drain normally.
- Combinational outputs:
  - out_onehot = out_vld ? (1 << out_idx) : 0.
  - pend_cnt = popcount(pend).
- No X on any output after the first reset edge.

Test Plan:
1. Reset: drive inpt=8'hFF, enb=1 for 3 cycles, then rst=1 for one edge → pend=0, out_vld=0, out_idx=0, ovf=0, pend_cnt=0 on the next cycle.
2. Single event: after reset, inpt=8'b0010_0000 for one cycle, out_rdy=1.
   - pend=8'h20 after edge 1.
   - out_vld=1, out_idx=5, out_onehot=8'h20 after edge 2.
   - out_vld=0 after edge 3.
3. Priority drain: inpt=8'b1000_0101 in one cycle, out_rdy=1 → out_idx sequence 7, 2, 0 on consecutive cycles; pend_cnt 3→2→1→0; then out_vld=0.
4. Backpressure: pend=8'h0A, out_rdy=0 for 5 cycles.
   - out_vld=1, out_idx=3 held stable; pend=8'h02.
   - Raise out_rdy → out_idx=1 next cycle, then out_vld=0.
5. Overflow and enb:
   - Hold out_rdy=0 with out_idx=7 presented, pend=8'h01. Pulse inpt[0] with enb=1 → ovf=1 and stays 1.
   - Pulse inpt[4] with enb=0 → pend unchanged at 8'h01.
6. Reload collision: pend=8'h40, out_vld=0, inpt[6]=1 in the same cycle → out_idx=6 loaded, pend remains 8'h40, ovf stays 0; index 6 is emitted twice in total.

Source files
------------

// File: rtl/onehot_event_encoder.sv
// Event-line encoder: captures up to N event requests into a pending register and
// presents them one at a time, highest index first, through a valid/ready stage.
module onehot_event_encoder #(
   parameter int N  = 8,
   parameter int IW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          enb,
   input  logic [N-1:0]  inpt,
   input  logic          out_rdy,
   output logic          out_vld,
   output logic [IW-1:0] out_idx,
   output logic [N-1:0]  out_onehot,
   output logic [N-1:0]  pend,
   output logic [IW:0]   pend_cnt,
   output logic          ovf
);

   logic [N-1:0]  r_pend;
   logic          r_vld;
   logic [IW-1:0] r_idx;
   logic          r_ovf;

   logic [IW-1:0] w_sel;
   logic          w_free;
   logic          w_load;
   logic [N-1:0]  w_clr;
   logic [N-1:0]  w_capt;
   logic [N-1:0]  w_merge;
   logic [IW:0]   w_cnt;

   // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      w_sel = '0;
      for (int i = 0; i < N; i++) begin
         if (r_pend[i]) w_sel = IW'(i);   // ascending scan: the last hit is the highest bit
      end
   end

   assign w_free  = !r_vld || out_rdy;
   assign w_load  = w_free && (r_pend != '0);
   assign w_clr   = w_load ? (N'(1) << w_sel) : '0;
   assign w_capt  = enb ? inpt : '0;
   // A bit re-requested in the very cycle it is loaded is a fresh event, not a merge.
   assign w_merge = w_capt & r_pend & ~w_clr;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pend <= '0;
         r_vld  <= 1'b0;
         r_idx  <= '0;
         r_ovf  <= 1'b0;
      end else begin
         r_pend <= (r_pend & ~w_clr) | w_capt;
         r_ovf  <= r_ovf | (|w_merge);
         if (w_load) begin
            r_vld <= 1'b1;
            r_idx <= w_sel;
         end else if (w_free) begin
            r_vld <= 1'b0;
         end
      end
   end

   always_comb begin
      w_cnt = '0;
      for (int i = 0; i < N; i++) begin
         w_cnt = w_cnt + (IW+1)'(r_pend[i]);
      end
   end

   assign out_vld    = r_vld;
   assign out_idx    = r_idx;
   assign out_onehot = r_vld ? (N'(1) << r_idx) : '0;
   assign pend       = r_pend;
   assign pend_cnt   = w_cnt;
   assign ovf        = r_ovf;

endmodule
